mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the core's single memory bus port between instruction fetch (IF) and load/store (MEM) requesters, one outstanding transaction at a time. Sits between the IF/MEM stage logic and the bus bridge. Generates `if_stall_req` and `mem_stall_req` for the hazard unit. Absorbs IF cancellations caused by control or exception transfers by draining the in-flight fetch and discarding its response.

## Interface
Parameters:
- `MAX_MEM_STREAK`, 4: consecutive MEM grants allowed while IF waits; the next grant then goes to IF.
- `CNT_W`, 3: width of the streak counter; must satisfy 2^CNT_W > MAX_MEM_STREAK.

Ports (clk, rst_n: one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `if_req` in 1: fetch request, level; held until `if_done` or cancel.
- `if_addr` in 64 (`REG_BUS`): fetch address.
- `if_cancel` in 1: one-cycle pulse; the current or pending fetch is void.
- `if_done` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 64: fetch data.
- `mem_req` in 1: load/store request, level; held until `mem_done`.
- `mem_wen` in 1: 1 = store.
- `mem_addr` in 64, `mem_wdata` in 64, `mem_wmask` in 8, `mem_size` in 2: store/load payload.
- `mem_done` out 1: one-cycle pulse; for loads, `mem_rdata` is valid.
- `mem_rdata` out 64: load data.
- `if_stall_req` out 1: `if_req & ~if_done`.
- `mem_stall_req` out 1: `mem_req & ~mem_done`.
- `bus_valid` out 1, `bus_ready` in 1: request handshake; transfer occurs when both are high.
- `bus_addr` out 64, `bus_wen` out 1, `bus_wdata` out 64, `bus_wmask` out 8, `bus_size` out 2, `bus_id` out 1 (0 = IF, 1 = MEM).
- `bus_rvalid` in 1, `bus_rdata` in 64: response, one cycle, exactly one per accepted request.

## Operation
States:
- IDLE: waiting for a request.
- REQ: `bus_valid` high, payload registers driving the bus.
- RESP: waiting for `bus_rvalid`.

Transitions:
- IDLE → REQ when an eligible request exists. The winner's payload is latched into registers and `owner` is set.
- REQ → RESP when `bus_valid & bus_ready`. `bus_valid` stays high and the payload stays stable until then.
- RESP → IDLE on `bus_rvalid`.
  - If owner = IF and `drop` = 0: pulse `if_done`.
  - If owner = MEM: pulse `mem_done`.
  - `bus_rdata` passes combinationally to `if_rdata` and `mem_rdata`.

Selection in IDLE:
- MEM has priority, unless `streak == MAX_MEM_STREAK` and `if_req` is high; then IF wins.
- `if_cancel` high in IDLE suppresses IF eligibility for that cycle.
- `streak` increments on each MEM grant made while `if_req` is high, saturating at `MAX_MEM_STREAK`. It clears on any IF grant and on a MEM grant made while `if_req` is low.

Cancel:
- If `if_cancel` arrives while owner = IF in REQ or RESP, set `drop`. The transaction still completes on the bus, but its response produces no `if_done`.
- `drop` clears on entry to IDLE.
- `if_cancel` while owner = MEM has no effect.

Writes: MEM stores also wait for `bus_rvalid`, used as the write acknowledge; `mem_rdata` is don't-care.

Reset state (all outputs):
- State IDLE, `owner` = 0, `drop` = 0, `streak` = 0.
- `bus_valid` = 0, all payload outputs = 0.
- `if_done` = 0, `mem_done` = 0.

## Timing
- Minimum latency: request seen in IDLE at cycle 0 → `bus_valid` at cycle 1 → `bus_ready` at cycle 1 → `bus_rvalid` no earlier than cycle 2 → `done` at cycle 2.
- Back-to-back: the next grant is decided in the IDLE cycle that follows the response, so bus throughput is at most one transaction per 3 cycles.
- `bus_rvalid` outside RESP is a protocol error. It is ignored; verification checks it with an assertion.
- Simultaneous `if_cancel` and `bus_rvalid` in RESP with owner = IF: the response is dropped and `if_done` stays 0.
- Requester lowering `req` while granted: illegal for MEM. For IF it is legal only together with `if_cancel`.
- `rst_n` asserted mid-transaction: the arbiter returns to IDLE immediately. The bus bridge is reset by the same `rst_n`.
- Stall outputs are combinational from `req` and `done`, so stall deasserts in the same cycle as `done`.

## Structure
- `defines.v` gains:
  - `REG_BUS`, already present.
  - `ARB_IDLE`, `ARB_REQ`, `ARB_RESP`: 2-bit state encodings.
  - `OWNER_IF` = 1'b0, `OWNER_MEM` = 1'b1.
- Single module, no sub-module. The streak counter and payload registers are inline.

## Test plan
1. IF only: `if_req`, `if_addr` = 0x8000_0000; bus ready immediately, `rvalid` 1 cycle later with 0x13 → `if_done` at cycle 2, `if_rdata` = 0x13, `bus_id` = 0.
2. Simultaneous `if_req` and `mem_req` (load 0x8000_1000) → MEM granted first (`bus_id` = 1); IF granted in the IDLE cycle after `mem_done`.
3. Starvation: `mem_req` held continuously with new requests each done, `if_req` held, `MAX_MEM_STREAK` = 4 → exactly 4 MEM transactions, then one IF transaction, then MEM resumes.
4. Cancel during RESP: IF owns the bus, `if_cancel` pulsed, `rvalid` 3 cycles later → no `if_done`. A new `if_req` at 0x8000_0040 is granted in the following IDLE cycle.
5. Backpressure: `bus_ready` held low 5 cycles for a store (`wmask` 0x0F, `wdata` 0xDEAD_BEEF) → `bus_valid` and payload stable throughout; `mem_done` follows `rvalid`.
6. `rst_n` low in RESP → all outputs 0 asynchronously; after release, a fresh IF request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned REG_BUS = 64;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbReq  = 2'd1,
        ArbResp = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    // Fetches always request a full doubleword.
    localparam logic [1:0] IF_SIZE = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the arbiter (master) and the bus bridge (slave).
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic               valid;
    logic               ready;
    logic [REG_BUS-1:0] addr;
    logic               wen;
    logic [REG_BUS-1:0] wdata;
    logic [7:0]         wmask;
    logic [1:0]         size;
    logic               id;
    logic               rvalid;
    logic [REG_BUS-1:0] rdata;

    modport master (
        output valid, addr, wen, wdata, wmask, size, id,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask, size, id,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory bus port between instruction fetch and load/store,
// one outstanding transaction at a time, with a MEM streak limit and IF cancel.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_MEM_STREAK = 4,
    parameter int unsigned CNT_W          = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [REG_BUS-1:0]  if_addr,
    input  logic                if_cancel,
    output logic                if_done,
    output logic [REG_BUS-1:0]  if_rdata,
    input  logic                mem_req,
    input  logic                mem_wen,
    input  logic [REG_BUS-1:0]  mem_addr,
    input  logic [REG_BUS-1:0]  mem_wdata,
    input  logic [7:0]          mem_wmask,
    input  logic [1:0]          mem_size,
    output logic                mem_done,
    output logic [REG_BUS-1:0]  mem_rdata,
    output logic                if_stall_req,
    output logic                mem_stall_req,
    mem_port_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_MEM_STREAK);

    arb_state_e       state;
    logic             owner;
    logic             drop;
    logic [CNT_W-1:0] streak;

    logic if_elig;
    logic if_win;
    logic mem_win;
    logic resp_fire;

    assign if_elig   = if_req & ~if_cancel;
    assign if_win    = if_elig & (~mem_req | (streak == STREAK_MAX));
    assign mem_win   = mem_req & ~if_win;
    assign resp_fire = (state == ArbResp) & bus.rvalid;

    // A cancel landing together with the response still suppresses if_done.
    assign if_done   = resp_fire & (owner == OWNER_IF) & ~drop & ~if_cancel;
    assign mem_done  = resp_fire & (owner == OWNER_MEM);
    assign if_rdata  = bus.rdata;
    assign mem_rdata = bus.rdata;

    assign if_stall_req  = if_req & ~if_done;
    assign mem_stall_req = mem_req & ~mem_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ArbIdle;
            owner     <= OWNER_IF;
            drop      <= 1'b0;
            streak    <= '0;
            bus.valid <= 1'b0;
            bus.addr  <= '0;
            bus.wen   <= 1'b0;
            bus.wdata <= '0;
            bus.wmask <= '0;
            bus.size  <= '0;
            bus.id    <= OWNER_IF;
        end else begin
            case (state)
                ArbIdle: begin
                    if (if_win) begin
                        state     <= ArbReq;
                        owner     <= OWNER_IF;
                        streak    <= '0;
                        bus.valid <= 1'b1;
                        bus.addr  <= if_addr;
                        bus.wen   <= 1'b0;
                        bus.wdata <= '0;
                        bus.wmask <= '0;
                        bus.size  <= IF_SIZE;
                        bus.id    <= OWNER_IF;
                    end else if (mem_win) begin
                        state     <= ArbReq;
                        owner     <= OWNER_MEM;
                        bus.valid <= 1'b1;
                        bus.addr  <= mem_addr;
                        bus.wen   <= mem_wen;
                        bus.wdata <= mem_wdata;
                        bus.wmask <= mem_wmask;
                        bus.size  <= mem_size;
                        bus.id    <= OWNER_MEM;
                        // Only grants that make a waiting fetch wait longer count.
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + CNT_W'(1);
                        end
                    end
                end
                ArbReq: begin
                    if (if_cancel && owner == OWNER_IF) begin
                        drop <= 1'b1;
                    end
                    if (bus.ready) begin
                        state     <= ArbResp;
                        bus.valid <= 1'b0;
                    end
                end
                ArbResp: begin
                    if (bus.rvalid) begin
                        state <= ArbIdle;
                        drop  <= 1'b0;
                    end else if (if_cancel && owner == OWNER_IF) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state <= ArbIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench plays both
// requesters and the bus bridge cycle by cycle.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_cancel, mem_req, mem_wen;
    logic [63:0] if_addr, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic [1:0]  mem_size;
    logic        if_done, mem_done, if_stall_req, mem_stall_req;
    logic [63:0] if_rdata, mem_rdata;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_MEM_STREAK (4),
        .CNT_W          (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_cancel     (if_cancel),
        .if_done       (if_done),
        .if_rdata      (if_rdata),
        .mem_req       (mem_req),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_size      (mem_size),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .if_stall_req  (if_stall_req),
        .mem_stall_req (mem_stall_req),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with the winning request already driven.
    task automatic txn(input string tag, input logic id, input logic [63:0] addr,
                       input logic wen, input logic [63:0] wdata, input logic [7:0] wmask,
                       input logic [1:0] size, input logic [63:0] rdata,
                       input int ready_wait, input int resp_wait);
        tick();
        for (int i = 0; i <= ready_wait; i++) begin
            bus.ready = (i == ready_wait);
            #1;
            chk({tag, ".valid"}, 64'(bus.valid), 64'd1);
            chk({tag, ".id"},    64'(bus.id),    64'(id));
            chk({tag, ".addr"},  bus.addr,       addr);
            chk({tag, ".wen"},   64'(bus.wen),   64'(wen));
            chk({tag, ".wdata"}, bus.wdata,      wdata);
            chk({tag, ".wmask"}, 64'(bus.wmask), 64'(wmask));
            chk({tag, ".size"},  64'(bus.size),  64'(size));
            tick();
        end
        bus.ready = 1'b0;
        for (int i = 0; i < resp_wait; i++) begin
            #1;
            chk({tag, ".resp_valid"}, 64'(bus.valid), 64'd0);
            chk({tag, ".early_done"}, 64'(if_done | mem_done), 64'd0);
            tick();
        end
        bus.rvalid = 1'b1;
        bus.rdata  = rdata;
        #1;
        if (id) begin
            chk({tag, ".mem_done"},  64'(mem_done),      64'd1);
            chk({tag, ".mem_rdata"}, mem_rdata,          rdata);
            chk({tag, ".mem_stall"}, 64'(mem_stall_req), 64'd0);
            chk({tag, ".if_done"},   64'(if_done),       64'd0);
            chk({tag, ".if_stall"},  64'(if_stall_req),  64'(if_req));
        end else begin
            chk({tag, ".if_done"},   64'(if_done),       64'd1);
            chk({tag, ".if_rdata"},  if_rdata,           rdata);
            chk({tag, ".if_stall"},  64'(if_stall_req),  64'd0);
            chk({tag, ".mem_done"},  64'(mem_done),      64'd0);
            chk({tag, ".mem_stall"}, 64'(mem_stall_req), 64'(mem_req));
        end
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_cancel = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_wmask = '0; mem_size = '0;
        bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        #2;
        chk("rst.valid", 64'(bus.valid), 64'd0);
        chk("rst.addr",  bus.addr,       64'd0);
        chk("rst.wdata", bus.wdata,      64'd0);
        chk("rst.wmask", 64'(bus.wmask), 64'd0);
        chk("rst.size",  64'(bus.size),  64'd0);
        chk("rst.id",    64'(bus.id),    64'd0);
        chk("rst.done",  64'(if_done | mem_done), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // IF only, minimum latency
        if_req = 1'b1; if_addr = 64'h8000_0000;
        #1;
        chk("t1.stall", 64'(if_stall_req), 64'd1);
        txn("t1", 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, IF_SIZE, 64'h13, 0, 0);
        if_req = 1'b0;
        tick();
        chk("t1.idle", 64'(bus.valid), 64'd0);

        // simultaneous requests: MEM first, then IF
        if_req = 1'b1; if_addr = 64'h8000_0004;
        mem_req = 1'b1; mem_addr = 64'h8000_1000; mem_size = 2'b11;
        txn("t2m", 1'b1, 64'h8000_1000, 1'b0, 64'd0, 8'h00, 2'b11, 64'hAA55, 0, 0);
        mem_req = 1'b0;
        txn("t2i", 1'b0, 64'h8000_0004, 1'b0, 64'd0, 8'h00, IF_SIZE, 64'h77, 0, 0);
        if_req = 1'b0;

        // starvation limit: four MEM grants, one IF, then MEM again
        if_req = 1'b1; if_addr = 64'h8000_0008; mem_req = 1'b1; mem_size = 2'b10;
        for (int k = 0; k < 4; k++) begin
            mem_addr = 64'h8000_1100 + 64'(k * 8);
            txn("t3m", 1'b1, mem_addr, 1'b0, 64'd0, 8'h00, 2'b10, 64'(k), 0, 0);
        end
        mem_addr = 64'h8000_1200;
        txn("t3i", 1'b0, 64'h8000_0008, 1'b0, 64'd0, 8'h00, IF_SIZE, 64'h99, 0, 0);
        if_req = 1'b0;
        txn("t3r", 1'b1, 64'h8000_1200, 1'b0, 64'd0, 8'h00, 2'b10, 64'h5, 0, 0);
        mem_req = 1'b0;

        // cancel in IDLE blocks the grant for that cycle
        if_req = 1'b1; if_cancel = 1'b1; if_addr = 64'h8000_0010;
        tick();
        if_cancel = 1'b0;
        #1;
        chk("cidle.valid", 64'(bus.valid), 64'd0);
        txn("cidle", 1'b0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, IF_SIZE, 64'h10, 0, 0);
        if_req = 1'b0;

        // cancel coinciding with the response
        if_req = 1'b1; if_addr = 64'h8000_0018;
        tick();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 64'h18;
        if_cancel = 1'b1; if_req = 1'b0;
        #1;
        chk("csim.if_done", 64'(if_done), 64'd0);
        tick();
        bus.rvalid = 1'b0; if_cancel = 1'b0;

        // cancel during RESP, response 3 cycles later, then a new fetch
        if_req = 1'b1; if_addr = 64'h8000_0020;
        tick();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0; if_cancel = 1'b1; if_req = 1'b0;
        #1;
        chk("t4.cancel_done", 64'(if_done), 64'd0);
        tick();
        if_cancel = 1'b0;
        tick();
        chk("t4.wait_valid", 64'(bus.valid), 64'd0);
        tick();
        bus.rvalid = 1'b1; bus.rdata = 64'hBAD;
        if_req = 1'b1; if_addr = 64'h8000_0040;
        #1;
        chk("t4.if_done", 64'(if_done), 64'd0);
        chk("t4.stall",   64'(if_stall_req), 64'd1);
        tick();
        bus.rvalid = 1'b0;
        txn("t4", 1'b0, 64'h8000_0040, 1'b0, 64'd0, 8'h00, IF_SIZE, 64'h40, 0, 0);
        if_req = 1'b0;

        // store under backpressure
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 64'h8000_2000;
        mem_wdata = 64'hDEAD_BEEF; mem_wmask = 8'h0F; mem_size = 2'b10;
        txn("t5", 1'b1, 64'h8000_2000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 2'b10, 64'd0, 5, 1);
        mem_req = 1'b0; mem_wen = 1'b0;

        // stray response in IDLE is ignored
        bus.rvalid = 1'b1;
        #1;
        chk("stray.done", 64'(if_done | mem_done), 64'd0);
        tick();
        bus.rvalid = 1'b0;
        #1;
        chk("stray.valid", 64'(bus.valid), 64'd0);

        // reset in RESP
        if_req = 1'b1; if_addr = 64'h8000_0050;
        tick();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        #2;
        rst_n = 1'b0;
        bus.rvalid = 1'b1;
        #1;
        chk("t6.valid", 64'(bus.valid), 64'd0);
        chk("t6.addr",  bus.addr,       64'd0);
        chk("t6.size",  64'(bus.size),  64'd0);
        chk("t6.done",  64'(if_done),   64'd0);
        bus.rvalid = 1'b0;
        tick();
        rst_n = 1'b1; if_addr = 64'h8000_0060;
        txn("t6", 1'b0, 64'h8000_0060, 1'b0, 64'd0, 8'h00, IF_SIZE, 64'h60, 0, 0);
        if_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
